ejtag_dmatch_gen2: RTL

Parametrised next-generation EJTAG data-breakpoint unit: NDBRK channels compare the W-stage load/store address, byte enables and data against per-channel breakpoint registers. New over the previous generation: load/store type qualification, byte-lane-aware match, per-channel pass counters, and a hit-record trace FIFO readable over the EJTAG register port. Sits between the load/store W-stage and the EJTAG probe register block; drives break/trace requests to CP0.

---
 rtl/ejtag_dmatch_gen2.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ejtag_dmatch_gen2.sv
// rtl/ejtag_dmatch_gen2.sv - EJTAG data-breakpoint channels with pass counters and hit trace FIFO
module ejtag_dmatch_gen2 #(
    parameter int NDBRK  = 4,
    parameter int PCW    = 8,
    parameter int TDEPTH = 8
) (
    input  logic             CORE_CLOCK,
    input  logic             RESET_D1_R,
    input  logic [31:0]      EJDI_DATA,
    input  logic [5:0]       EJDI_ADDR,
    input  logic             EJDI_RW,
    input  logic             EJ_STROBE,
    input  logic             EJDI_SELDBRS,
    input  logic             EJDI_SELDBS,
    input  logic             EJDI_SELDBT,
    input  logic             LW_DSAMPLE_W,
    input  logic             LW_DSTORE_W,
    input  logic [3:0]       LW_DBE_W_R,
    input  logic [29:0]      LW_DADDR_W_R,
    input  logic [31:0]      LW_DATA_W_R,
    input  logic             CP0_DBREAKCLR,
    output logic [31:0]      EJDM_DATA,
    output logic             EJDM_BREAKHIT,
    output logic             EJDM_TRACEHIT,
    output logic [NDBRK-1:0] EJDM_HIT,
    output logic             EJDM_TNEMPTY
);
    localparam int AW = $clog2(TDEPTH);
    localparam logic [AW:0] FULL_COUNT = TDEPTH[AW:0];

    logic [29:0]      ch_addr  [NDBRK];
    logic [29:0]      ch_amask [NDBRK];
    logic [31:0]      ch_data  [NDBRK];
    logic [3:0]       ch_ign   [NDBRK];
    logic [PCW-1:0]   ch_cnt   [NDBRK];
    logic [NDBRK-1:0] ch_be, ch_te, ch_lden, ch_sten;

    logic [3:0]       lane_en  [NDBRK];
    logic [NDBRK-1:0] data_ok, raw_match, qual;
    logic [NDBRK-1:0] hit_q, status;
    logic             break_q, trace_q, trace_ovf;

    logic [29:0]      fifo_addr [TDEPTH];
    logic [TDEPTH-1:0] fifo_store;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_count;
    logic             fifo_empty, fifo_full, push, pop, push_ok;

    logic [3:0] ch_sel;
    logic [1:0] reg_sel;
    logic       wr_bank, wr_status;

    assign ch_sel    = EJDI_ADDR[5:2];
    assign reg_sel   = EJDI_ADDR[1:0];
    assign wr_bank   = EJ_STROBE & ~EJDI_RW & EJDI_SELDBRS;
    assign wr_status = EJ_STROBE & ~EJDI_RW & EJDI_SELDBS;

    // Per-channel raw match and pass-counter qualification of the W-stage access
    always_comb begin
        raw_match = '0;
        qual      = '0;
        data_ok   = '1;
        for (int i = 0; i < NDBRK; i++) begin
            lane_en[i] = LW_DBE_W_R & ~ch_ign[i];
            for (int b = 0; b < 4; b++) begin
                if (lane_en[i][b] && (LW_DATA_W_R[8*b +: 8] != ch_data[i][8*b +: 8])) begin
                    data_ok[i] = 1'b0;
                end
            end
            raw_match[i] = LW_DSAMPLE_W
                && (((LW_DADDR_W_R ^ ch_addr[i]) & ~ch_amask[i]) == 30'd0)
                && (LW_DSTORE_W ? ch_sten[i] : ch_lden[i])
                && data_ok[i]
                && ((lane_en[i] != 4'd0) || (ch_ign[i] == 4'hF));
            qual[i] = raw_match[i] && (ch_cnt[i] == '0);
        end
    end

    // Channel configuration writes; a CTRL write reloads the pass counter over any decrement
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            for (int i = 0; i < NDBRK; i++) begin
                ch_addr[i]  <= '0;
                ch_amask[i] <= '0;
                ch_data[i]  <= '0;
                ch_ign[i]   <= '0;
                ch_cnt[i]   <= '0;
            end
            ch_be   <= '0;
            ch_te   <= '0;
            ch_lden <= '0;
            ch_sten <= '0;
        end else begin
            for (int i = 0; i < NDBRK; i++) begin
                if (wr_bank && (ch_sel == 4'(i))) begin
                    case (reg_sel)
                        2'b00: ch_addr[i] <= EJDI_DATA[31:2];
                        2'b01: begin
                            ch_be[i]   <= EJDI_DATA[0];
                            ch_te[i]   <= EJDI_DATA[2];
                            ch_ign[i]  <= EJDI_DATA[7:4];
                            ch_lden[i] <= EJDI_DATA[8];
                            ch_sten[i] <= EJDI_DATA[9];
                        end
                        2'b10:   ch_amask[i] <= EJDI_DATA[31:2];
                        default: ch_data[i]  <= EJDI_DATA;
                    endcase
                end
                if (wr_bank && (ch_sel == 4'(i)) && (reg_sel == 2'b01)) begin
                    ch_cnt[i] <= EJDI_DATA[16 +: PCW];
                end else if (raw_match[i] && (ch_cnt[i] != '0)) begin
                    ch_cnt[i] <= ch_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Registered hit outputs, dropped by a debug-break clear
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R || CP0_DBREAKCLR) begin
            hit_q   <= '0;
            break_q <= 1'b0;
            trace_q <= 1'b0;
        end else begin
            hit_q   <= qual;
            break_q <= |(qual & ch_be);
            trace_q <= |(qual & ch_te);
        end
    end

    // Sticky status: software write wins, a colliding hit lands next cycle via hit_q
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R || CP0_DBREAKCLR) begin
            status <= '0;
        end else if (wr_status) begin
            status <= EJDI_DATA[NDBRK-1:0];
        end else begin
            status <= status | qual | hit_q;
        end
    end

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign push       = |(qual & ch_te);
    assign pop        = EJ_STROBE & EJDI_RW & EJDI_SELDBT & ~EJDI_SELDBRS & ~EJDI_SELDBS & ~fifo_empty;
    assign push_ok    = push & (~fifo_full | pop);

    // Trace overflow flag: set on a dropped push, cleared by status write bit 23
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            trace_ovf <= 1'b0;
        end else if (push && !push_ok) begin
            trace_ovf <= 1'b1;
        end else if (wr_status && EJDI_DATA[23]) begin
            trace_ovf <= 1'b0;
        end
    end

    // Trace FIFO pointers and occupancy; pop is taken before push when full
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Trace FIFO storage
    always_ff @(posedge CORE_CLOCK) begin
        if (push_ok) begin
            fifo_addr[wr_ptr]  <= LW_DADDR_W_R;
            fifo_store[wr_ptr] <= LW_DSTORE_W;
        end
    end

    // Register read mux
    always_comb begin
        EJDM_DATA = 32'd0;
        if (EJDI_SELDBRS) begin
            for (int i = 0; i < NDBRK; i++) begin
                if (ch_sel == 4'(i)) begin
                    case (reg_sel)
                        2'b00:   EJDM_DATA = {ch_addr[i], 2'b00};
                        2'b01:   EJDM_DATA[16 +: PCW] = ch_cnt[i];
                        2'b10:   EJDM_DATA = {ch_amask[i], 2'b00};
                        default: EJDM_DATA = ch_data[i];
                    endcase
                end
            end
        end else if (EJDI_SELDBS) begin
            EJDM_DATA[27:24]      = 4'(NDBRK);
            EJDM_DATA[23]         = trace_ovf;
            EJDM_DATA[NDBRK-1:0]  = status;
        end else if (EJDI_SELDBT && !fifo_empty) begin
            EJDM_DATA = {fifo_addr[rd_ptr], fifo_store[rd_ptr], 1'b1};
        end
    end

    assign EJDM_HIT      = hit_q;
    assign EJDM_BREAKHIT = break_q;
    assign EJDM_TRACEHIT = trace_q;
    assign EJDM_TNEMPTY  = ~fifo_empty;
endmodule
